multi_issue_ctrl: RTL and testbench
===================================

# multi_issue_ctrl

Parametrised in-order N-wide issue stage that sits between the issue queue and the execute functional units. It owns the register scoreboard (producer lane, pipeline position, bypass accept mask per architectural register) and selects the longest issuable prefix of the queue head each cycle. For each operand it resolves the immediate, register-file or bypass source, and registers the issued group into the FU pipeline register. Successor to the fixed dual-issue stage: it adds width/depth parameters, EX stall, flush, WAW handling and an output register.

## Interface
- ISSUE_WIDTH, 2, lanes issued per cycle (1..4)
- PIPE_DEPTH, 3, in-flight position bits (stages with a bypass tap)
- PAYLOAD_W, 96, opaque FU control bits passed through (alu_op, exe_type, mem fields, predict_pc...)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- iq_size  in  clog2(ISSUE_WIDTH+1)  valid entries at queue head
- iq_payload  in  ISSUE_WIDTH*PAYLOAD_W  per-lane control payload, lane 0 oldest
- iq_src_need / iq_src_addr / iq_src_imm  in  ISSUE_WIDTH*2 / *2*5 / *2*32  per-operand register-needed flag, address, immediate
- iq_dst_need / iq_dst_addr / iq_accept_mask / iq_is_branch  in  ISSUE_WIDTH / *5 / *PIPE_DEPTH / ISSUE_WIDTH
- iq_pop_number  out  clog2(ISSUE_WIDTH+1)  entries consumed this cycle
- regfile_read_addr  out  ISSUE_WIDTH*2*5  equals iq_src_addr
- regfile_read_data  in  ISSUE_WIDTH*2*32
- bypass_sel  out  ISSUE_WIDTH*2*(PIPE_DEPTH+clog2(ISSUE_WIDTH))  per-operand stage one-hot + producer lane
- bypass_result  in  ISSUE_WIDTH*2*32  data for bypass_sel, same cycle
- ex_stall  in  1  EX cannot accept; freeze
- flush  in  1  kill younger work (branch mispredict)
- fu_valid  out  ISSUE_WIDTH  registered lane valid
- fu_payload / fu_num1 / fu_num2  out  ISSUE_WIDTH*PAYLOAD_W / *32 / *32  registered

## Operation
- Scoreboard per reg r (r=0 never tracked, always ready from regfile): line, position[PIPE_DEPTH-1:0] (at most one bit set), accept_mask.
- Operand ready: src_need=0 -> imm; position==0 -> regfile_read_data; (position & accept_mask)!=0 -> bypass_result, bypass_sel={position, line}; otherwise not ready.
- Intra-group RAW: lane i operand matching dst_addr of any issuing lane j<i with dst_need -> not ready (no same-cycle forwarding).
- Issue count k = longest prefix of lanes 0..iq_size-1 with all operands ready; k limited to iq_size.
- Branch rule (see Configuration): a branch in lane k-1 whose delay slot (lane k) is absent or not ready is dropped from the group; k decreases by 1.
- Issue write: for each issued lane with dst_need, entry <= {line=lane, position=1<<(PIPE_DEPTH-1), accept_mask}. Two issued lanes with the same dst: higher lane wins.
- Advance: every non-stalled cycle, all other positions shift right by 1; 1 -> 0 means written back. A new issue write to r overrides r's shift.
- ex_stall=1: k=0, pop=0, no scoreboard shift, fu_* held.
- flush=1: k=0, pop=0, fu_valid<=0. Entries with position MSB set (the killed group in the FU register) are cleared to 0. All other entries shift normally. flush has priority over ex_stall.

## Timing
- Decision combinational from iq_*/regfile/bypass; iq_pop_number valid same cycle.
- fu_* registered: lane issued in cycle t appears at fu_* in t+1.
- Scoreboard update visible to the next cycle's decision. Back-to-back dependent ALU ops with accept_mask MSB set issue in consecutive cycles.
- Reset: fu_valid=0, fu_payload/num1/num2=0, all scoreboard entries 0, iq_pop_number=0 while rst is asserted.
- Reset mid-operation discards in-flight entries on the next edge.

## Configuration
- ISSUE_BRANCH_DELAY_EN defined: the branch/delay-slot pairing rule applies; a branch never issues without its delay slot in the same group.
- Not defined: branches are treated as ordinary lanes. The delay slot may issue in a later cycle (used by cores without delay slots).

## Test plan
- ISSUE_WIDTH=2, iq_size=2, independent ops r1=r2+r3, r4=r5+imm5 -> pop=2; next cycle fu_valid=2'b11, position[r1]=3'b100, position[r4]=3'b100.
- Lane0 writes r1, lane1 reads r1 -> pop=1. Next cycle lane1 (now head) accept_mask=3'b100 -> issues with bypass_sel stage=3'b100, line=0.
- Load r7 with accept_mask=3'b001, consumer reads r7 -> stalls 2 cycles, issues in the 3rd with bypass stage 3'b001.
- Define ISSUE_BRANCH_DELAY_EN, iq_size=1, lane0 branch -> pop=0; iq_size=2 with ready slot -> pop=2. Undefine the macro -> pop=1 for iq_size=1.
- ex_stall=1 for 3 cycles with r1 at 3'b100 -> position stays 3'b100, pop=0, fu_* unchanged.
- Flush the cycle after issuing r9 -> fu_valid=0, position[r9]=0, and an older r8 at 3'b010 advances to 3'b001.

Source files
------------

// File: rtl/multi_issue_ctrl_if.sv
// Bundle between the in-order issue stage, the issue queue, register file,
// bypass network and the FU pipeline register. Lane 0 is the oldest entry.
interface multi_issue_ctrl_if #(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned PIPE_DEPTH  = 3,
    parameter int unsigned PAYLOAD_W   = 96
);
    localparam int unsigned SIZE_W = $clog2(ISSUE_WIDTH + 1);
    localparam int unsigned LINE_W = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
    localparam int unsigned SEL_W  = PIPE_DEPTH + LINE_W;
    localparam int unsigned OPS    = ISSUE_WIDTH * 2;

    logic [SIZE_W-1:0]                 iq_size;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0]  iq_payload;
    logic [OPS-1:0]                    iq_src_need;
    logic [OPS*5-1:0]                  iq_src_addr;
    logic [OPS*32-1:0]                 iq_src_imm;
    logic [ISSUE_WIDTH-1:0]            iq_dst_need;
    logic [ISSUE_WIDTH*5-1:0]          iq_dst_addr;
    logic [ISSUE_WIDTH*PIPE_DEPTH-1:0] iq_accept_mask;
    logic [ISSUE_WIDTH-1:0]            iq_is_branch;
    logic [SIZE_W-1:0]                 iq_pop_number;
    logic [OPS*5-1:0]                  regfile_read_addr;
    logic [OPS*32-1:0]                 regfile_read_data;
    logic [OPS*SEL_W-1:0]              bypass_sel;
    logic [OPS*32-1:0]                 bypass_result;
    logic                              ex_stall;
    logic                              flush;
    logic [ISSUE_WIDTH-1:0]            fu_valid;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0]  fu_payload;
    logic [ISSUE_WIDTH*32-1:0]         fu_num1;
    logic [ISSUE_WIDTH*32-1:0]         fu_num2;

    // Issue stage side
    modport slave (
        input  iq_size, iq_payload, iq_src_need, iq_src_addr, iq_src_imm,
               iq_dst_need, iq_dst_addr, iq_accept_mask, iq_is_branch,
               regfile_read_data, bypass_result, ex_stall, flush,
        output iq_pop_number, regfile_read_addr, bypass_sel,
               fu_valid, fu_payload, fu_num1, fu_num2
    );

    // Queue / datapath / FU side
    modport master (
        output iq_size, iq_payload, iq_src_need, iq_src_addr, iq_src_imm,
               iq_dst_need, iq_dst_addr, iq_accept_mask, iq_is_branch,
               regfile_read_data, bypass_result, ex_stall, flush,
        input  iq_pop_number, regfile_read_addr, bypass_sel,
               fu_valid, fu_payload, fu_num1, fu_num2
    );
endinterface

// File: rtl/multi_issue_ctrl.sv
// In-order N-wide issue stage: register scoreboard, operand source select and FU register.
// Define ISSUE_BRANCH_DELAY_EN to keep a branch and its delay slot in the same issue group.
module multi_issue_ctrl #(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned PIPE_DEPTH  = 3,
    parameter int unsigned PAYLOAD_W   = 96
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_issue_ctrl_if.slave    bus
);
    localparam int unsigned SIZE_W  = $clog2(ISSUE_WIDTH + 1);
    localparam int unsigned LINE_W  = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
    localparam int unsigned SEL_W   = PIPE_DEPTH + LINE_W;
    localparam int unsigned OPS     = ISSUE_WIDTH * 2;
    localparam int unsigned NUM_REG = 32;
    localparam logic [PIPE_DEPTH-1:0] POS_TOP = PIPE_DEPTH'(1) << (PIPE_DEPTH - 1);

    // Scoreboard: producer lane, one-hot pipeline position, stages able to bypass
    logic [LINE_W-1:0]     sb_line [NUM_REG];
    logic [PIPE_DEPTH-1:0] sb_pos  [NUM_REG];
    logic [PIPE_DEPTH-1:0] sb_mask [NUM_REG];

    logic [OPS-1:0]         op_rdy;
    logic [31:0]            op_num [OPS];
    logic [ISSUE_WIDTH-1:0] lane_ok;
    logic                   prefix_open;
    logic [SIZE_W-1:0]      issue_cnt;

    assign bus.regfile_read_addr = bus.iq_src_addr;
    assign bus.iq_pop_number     = issue_cnt;

    // Operand source resolution: immediate, register file, bypass, or not ready
    always_comb begin : operand_resolve
        bus.bypass_sel = '0;
        for (int o = 0; o < OPS; o++) begin
            op_rdy[o] = 1'b0;
            op_num[o] = 32'd0;
            if (!bus.iq_src_need[o]) begin
                op_rdy[o] = 1'b1;
                op_num[o] = bus.iq_src_imm[o*32 +: 32];
            end else if (bus.iq_src_addr[o*5 +: 5] == 5'd0 ||
                         sb_pos[bus.iq_src_addr[o*5 +: 5]] == '0) begin
                op_rdy[o] = 1'b1;
                op_num[o] = bus.regfile_read_data[o*32 +: 32];
            end else if ((sb_pos[bus.iq_src_addr[o*5 +: 5]] &
                          sb_mask[bus.iq_src_addr[o*5 +: 5]]) != '0) begin
                op_rdy[o] = 1'b1;
                op_num[o] = bus.bypass_result[o*32 +: 32];
                bus.bypass_sel[o*SEL_W +: SEL_W] = {sb_pos[bus.iq_src_addr[o*5 +: 5]],
                                                    sb_line[bus.iq_src_addr[o*5 +: 5]]};
            end
            // No same-cycle forwarding from an older lane of the same group
            for (int j = 0; j < o / 2; j++) begin
                if (bus.iq_src_need[o] && bus.iq_dst_need[j] &&
                    bus.iq_src_addr[o*5 +: 5] != 5'd0 &&
                    bus.iq_dst_addr[j*5 +: 5] == bus.iq_src_addr[o*5 +: 5]) begin
                    op_rdy[o] = 1'b0;
                end
            end
        end
    end

`ifdef ISSUE_BRANCH_DELAY_EN
    logic branch_drop;
`else
    logic branch_unused;
    assign branch_unused = ^bus.iq_is_branch;
`endif

    // Longest ready prefix of the queue head
    always_comb begin : issue_select
        issue_cnt   = '0;
        prefix_open = 1'b1;
        lane_ok     = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            lane_ok[i] = op_rdy[2*i] && op_rdy[2*i+1];
            if (prefix_open && (i < int'(bus.iq_size)) && lane_ok[i]) begin
                issue_cnt = SIZE_W'(i + 1);
            end else begin
                prefix_open = 1'b0;
            end
        end
`ifdef ISSUE_BRANCH_DELAY_EN
        // A branch closing the group has no delay slot alongside it
        branch_drop = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (int'(issue_cnt) == i + 1 && bus.iq_is_branch[i]) begin
                branch_drop = 1'b1;
            end
        end
        if (branch_drop) begin
            issue_cnt = issue_cnt - SIZE_W'(1);
        end
`endif
        if (rst || bus.ex_stall || bus.flush) begin
            issue_cnt = '0;
        end
    end

    // FU pipeline register
    always_ff @(posedge clk) begin : fu_reg
        if (rst) begin
            bus.fu_valid   <= '0;
            bus.fu_payload <= '0;
            bus.fu_num1    <= '0;
            bus.fu_num2    <= '0;
        end else if (bus.flush) begin
            bus.fu_valid <= '0;
        end else if (!bus.ex_stall) begin
            bus.fu_payload <= bus.iq_payload;
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                bus.fu_valid[i]         <= (i < int'(issue_cnt));
                bus.fu_num1[i*32 +: 32] <= op_num[2*i];
                bus.fu_num2[i*32 +: 32] <= op_num[2*i+1];
            end
        end
    end

    // Scoreboard advance; a new issue write overrides the shift, higher lane last
    always_ff @(posedge clk) begin : scoreboard
        if (rst) begin
            for (int r = 0; r < NUM_REG; r++) begin
                sb_line[r] <= '0;
                sb_pos[r]  <= '0;
                sb_mask[r] <= '0;
            end
        end else if (bus.flush) begin
            for (int r = 0; r < NUM_REG; r++) begin
                if (sb_pos[r][PIPE_DEPTH-1]) begin
                    sb_line[r] <= '0;
                    sb_pos[r]  <= '0;
                    sb_mask[r] <= '0;
                end else begin
                    sb_pos[r] <= sb_pos[r] >> 1;
                end
            end
        end else if (!bus.ex_stall) begin
            for (int r = 0; r < NUM_REG; r++) begin
                sb_pos[r] <= sb_pos[r] >> 1;
            end
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if ((i < int'(issue_cnt)) && bus.iq_dst_need[i] &&
                    bus.iq_dst_addr[i*5 +: 5] != 5'd0) begin
                    sb_line[bus.iq_dst_addr[i*5 +: 5]] <= LINE_W'(i);
                    sb_pos[bus.iq_dst_addr[i*5 +: 5]]  <= POS_TOP;
                    sb_mask[bus.iq_dst_addr[i*5 +: 5]] <= bus.iq_accept_mask[i*PIPE_DEPTH +: PIPE_DEPTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_issue_ctrl.sv
// Scoreboard-driven bench for multi_issue_ctrl (2 lanes, depth 3).
// Expectations for the branch rule follow ISSUE_BRANCH_DELAY_EN as compiled.
module tb_multi_issue_ctrl;
    localparam int unsigned W     = 2;
    localparam int unsigned D     = 3;
    localparam int unsigned PW    = 96;
    localparam int unsigned OPS   = 4;
    localparam int unsigned SEL_W = 4;

    typedef struct packed {
        logic [1:0]   v;
        logic [63:0]  n1;
        logic [63:0]  n2;
        logic [191:0] pay;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    multi_issue_ctrl_if #(.ISSUE_WIDTH(W), .PIPE_DEPTH(D), .PAYLOAD_W(PW)) bus ();

    multi_issue_ctrl #(.ISSUE_WIDTH(W), .PIPE_DEPTH(D), .PAYLOAD_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file returns a tag of the address; bypass returns a tag of operand and select
    always_comb begin
        for (int o = 0; o < OPS; o++) begin
            bus.regfile_read_data[o*32 +: 32] = 32'h1000_0000 | 32'(bus.regfile_read_addr[o*5 +: 5]);
            bus.bypass_result[o*32 +: 32]     = 32'hB000_0000 | 32'({2'(o), bus.bypass_sel[o*SEL_W +: SEL_W]});
        end
    end

    function automatic logic [31:0] rf(input logic [4:0] a);
        return 32'h1000_0000 | 32'(a);
    endfunction

    function automatic logic [31:0] byp(input int o, input logic [3:0] sel);
        return 32'hB000_0000 | 32'({2'(o), sel});
    endfunction

    function automatic logic [31:0] imm_of(input int o);
        return 32'hA000_0000 | 32'(o);
    endfunction

    function automatic logic [95:0] pay_of(input logic [7:0] tag);
        return {tag, 80'h5A5A_0000_0000_0000_1234, tag};
    endfunction

    function automatic exp_t mk(input logic [1:0] v,
                                input logic [31:0] a0, input logic [31:0] b0, input logic [95:0] p0,
                                input logic [31:0] a1, input logic [31:0] b1, input logic [95:0] p1);
        exp_t e;
        e.v   = v;
        e.n1  = {v[1] ? a1 : 32'h0, v[0] ? a0 : 32'h0};
        e.n2  = {v[1] ? b1 : 32'h0, v[0] ? b0 : 32'h0};
        e.pay = {v[1] ? p1 : 96'h0, v[0] ? p0 : 96'h0};
        return e;
    endfunction

    // Observed FU register, data of lanes not expected valid masked out
    function automatic exp_t fu_snap(input logic [1:0] v);
        exp_t e;
        e.v   = bus.fu_valid;
        e.n1  = {v[1] ? bus.fu_num1[63:32] : 32'h0, v[0] ? bus.fu_num1[31:0] : 32'h0};
        e.n2  = {v[1] ? bus.fu_num2[63:32] : 32'h0, v[0] ? bus.fu_num2[31:0] : 32'h0};
        e.pay = {v[1] ? bus.fu_payload[191:96] : 96'h0, v[0] ? bus.fu_payload[95:0] : 96'h0};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_iq();
        bus.iq_size        = '0;
        bus.iq_payload     = '0;
        bus.iq_src_need    = '0;
        bus.iq_src_addr    = '0;
        bus.iq_src_imm     = '0;
        bus.iq_dst_need    = '0;
        bus.iq_dst_addr    = '0;
        bus.iq_accept_mask = '0;
        bus.iq_is_branch   = '0;
    endtask

    task automatic set_lane(input int l, input logic [4:0] s1, input logic n1,
                            input logic [4:0] s2, input logic n2, input logic dn,
                            input logic [4:0] d, input logic [2:0] m, input logic br,
                            input logic [7:0] tag);
        bus.iq_src_need[2*l]              = n1;
        bus.iq_src_addr[2*l*5 +: 5]       = s1;
        bus.iq_src_imm[2*l*32 +: 32]      = imm_of(2*l);
        bus.iq_src_need[2*l+1]            = n2;
        bus.iq_src_addr[(2*l+1)*5 +: 5]   = s2;
        bus.iq_src_imm[(2*l+1)*32 +: 32]  = imm_of(2*l+1);
        bus.iq_dst_need[l]                = dn;
        bus.iq_dst_addr[l*5 +: 5]         = d;
        bus.iq_accept_mask[l*3 +: 3]      = m;
        bus.iq_is_branch[l]               = br;
        bus.iq_payload[l*96 +: 96]        = pay_of(tag);
    endtask

    task automatic drain();
        clear_iq();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        exp_t z;
        z = '0;
        rst = 1'b1;
        bus.ex_stall = 1'b0;
        bus.flush    = 1'b0;
        clear_iq();
        set_lane(0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1, 3'b100, 1'b0, 8'h01);
        set_lane(1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 3'b100, 1'b0, 8'h02);
        bus.iq_size = 2'd2;
        #1;
        n_tests++;
        if (bus.iq_pop_number !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_pop got %0d want 0", bus.iq_pop_number);
        end
        tick();
        tick();
        n_tests++;
        if ({bus.fu_valid, bus.fu_num1, bus.fu_num2, bus.fu_payload} !== {z.v, z.n1, z.n2, z.pay}) begin
            n_fail++;
            $display("FAIL reset_fu got v=%b n1=%h want all zero", bus.fu_valid, bus.fu_num1);
        end
        n_tests++;
        if (dut.sb_pos[1] !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_sb got %b want 000", dut.sb_pos[1]);
        end
        rst = 1'b0;
        clear_iq();
        tick();
    endtask

    task automatic test_independent();
        exp_t e;
        clear_iq();
        set_lane(0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1, 3'b100, 1'b0, 8'h10);
        set_lane(1, 5'd5, 1'b1, 5'd9, 1'b0, 1'b1, 5'd4, 3'b100, 1'b0, 8'h11);
        bus.iq_size = 2'd2;
        #1;
        n_tests++;
        if (bus.iq_pop_number !== 2'd2) begin
            n_fail++;
            $display("FAIL indep_pop got %0d want 2", bus.iq_pop_number);
        end
        exp_q.push_back(mk(2'b11, rf(5'd2), rf(5'd3), pay_of(8'h10), rf(5'd5), imm_of(3), pay_of(8'h11)));
        tick();
        clear_iq();
        e = exp_q.pop_front();
        n_tests++;
        if (fu_snap(e.v) !== e) begin
            n_fail++;
            $display("FAIL indep_fu got %h want %h", fu_snap(e.v), e);
        end
        n_tests++;
        if (dut.sb_pos[1] !== 3'b100 || dut.sb_pos[4] !== 3'b100) begin
            n_fail++;
            $display("FAIL indep_sb got r1=%b r4=%b want 100 100", dut.sb_pos[1], dut.sb_pos[4]);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        clear_iq();
        set_lane(0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1, 3'b100, 1'b0, 8'h20);
        set_lane(1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 3'b100, 1'b0, 8'h21);
        bus.iq_size = 2'd2;
        #1;
        n_tests++;
        if (bus.iq_pop_number !== 2'd1) begin
            n_fail++;
            $display("FAIL raw_pop got %0d want 1", bus.iq_pop_number);
        end
        exp_q.push_back(mk(2'b01, rf(5'd2), rf(5'd3), pay_of(8'h20), 32'h0, 32'h0, 96'h0));
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (fu_snap(e.v) !== e) begin
            n_fail++;
            $display("FAIL raw_fu got %h want %h", fu_snap(e.v), e);
        end
        clear_iq();
        set_lane(0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 3'b100, 1'b0, 8'h21);
        bus.iq_size = 2'd1;
        #1;
        n_tests++;
        if (bus.iq_pop_number !== 2'd1 || bus.bypass_sel[3:0] !== 4'b1000) begin
            n_fail++;
            $display("FAIL b2b_issue got pop=%0d sel=%b want 1 1000", bus.iq_pop_number, bus.bypass_sel[3:0]);
        end
        exp_q.push_back(mk(2'b01, byp(0, 4'b1000), imm_of(1), pay_of(8'h21), 32'h0, 32'h0, 96'h0));
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (fu_snap(e.v) !== e) begin
            n_fail++;
            $display("FAIL b2b_fu got %h want %h", fu_snap(e.v), e);
        end
        drain();
    endtask

    task automatic test_load_use();
        exp_t e;
        clear_iq();
        set_lane(0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 3'b001, 1'b0, 8'h30);
        bus.iq_size = 2'd1;
        #1;
        exp_q.push_back(mk(2'b01, rf(5'd2), imm_of(1), pay_of(8'h30), 32'h0, 32'h0, 96'h0));
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (fu_snap(e.v) !== e) begin
            n_fail++;
            $display("FAIL load_fu got %h want %h", fu_snap(e.v), e);
        end
        clear_iq();
        set_lane(0, 5'd7, 1'b1, 5'd0, 1'b1, 1'b1, 5'd8, 3'b100, 1'b0, 8'h31);
        bus.iq_size = 2'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (bus.iq_pop_number !== ((c == 2) ? 2'd1 : 2'd0)) begin
                n_fail++;
                $display("FAIL load_use_pop cycle %0d got %0d want %0d", c, bus.iq_pop_number, (c == 2) ? 1 : 0);
            end
            if (c == 2) begin
                exp_q.push_back(mk(2'b01, byp(0, 4'b0010), rf(5'd0), pay_of(8'h31), 32'h0, 32'h0, 96'h0));
            end else begin
                exp_q.push_back(mk(2'b00, 32'h0, 32'h0, 96'h0, 32'h0, 32'h0, 96'h0));
            end
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (fu_snap(e.v) !== e) begin
                n_fail++;
                $display("FAIL load_use_fu cycle %0d got %h want %h", c, fu_snap(e.v), e);
            end
        end
        drain();
    endtask

    task automatic test_branch();
        exp_t e;
        logic [1:0] want;
        clear_iq();
        set_lane(0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 3'b000, 1'b1, 8'h40);
        bus.iq_size = 2'd1;
        #1;
`ifdef ISSUE_BRANCH_DELAY_EN
        want = 2'd0;
`else
        want = 2'd1;
`endif
        n_tests++;
        if (bus.iq_pop_number !== want) begin
            n_fail++;
            $display("FAIL branch_alone_pop got %0d want %0d", bus.iq_pop_number, want);
        end
        exp_q.push_back(mk(want, rf(5'd2), rf(5'd3), pay_of(8'h40), 32'h0, 32'h0, 96'h0));
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (fu_snap(e.v) !== e) begin
            n_fail++;
            $display("FAIL branch_alone_fu got %h want %h", fu_snap(e.v), e);
        end
        set_lane(1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 3'b100, 1'b0, 8'h41);
        bus.iq_size = 2'd2;
        #1;
        n_tests++;
        if (bus.iq_pop_number !== 2'd2) begin
            n_fail++;
            $display("FAIL branch_pair_pop got %0d want 2", bus.iq_pop_number);
        end
        exp_q.push_back(mk(2'b11, rf(5'd2), rf(5'd3), pay_of(8'h40), rf(5'd4), imm_of(3), pay_of(8'h41)));
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (fu_snap(e.v) !== e) begin
            n_fail++;
            $display("FAIL branch_pair_fu got %h want %h", fu_snap(e.v), e);
        end
        drain();
        // Delay slot waiting on a load: the branch must wait with it when pairing is on
        set_lane(0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, 3'b001, 1'b0, 8'h42);
        bus.iq_size = 2'd1;
        tick();
        clear_iq();
        set_lane(0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 3'b000, 1'b1, 8'h43);
        set_lane(1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b1, 5'd12, 3'b100, 1'b0, 8'h44);
        bus.iq_size = 2'd2;
        #1;
        n_tests++;
        if (bus.iq_pop_number !== want) begin
            n_fail++;
            $display("FAIL branch_slot_wait_pop got %0d want %0d", bus.iq_pop_number, want);
        end
        drain();
    endtask

    task automatic test_stall();
        exp_t e;
        exp_t hold;
        clear_iq();
        set_lane(0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1, 3'b100, 1'b0, 8'h50);
        bus.iq_size = 2'd1;
        #1;
        hold = mk(2'b01, rf(5'd2), rf(5'd3), pay_of(8'h50), 32'h0, 32'h0, 96'h0);
        exp_q.push_back(hold);
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (fu_snap(e.v) !== e) begin
            n_fail++;
            $display("FAIL stall_issue_fu got %h want %h", fu_snap(e.v), e);
        end
        bus.ex_stall = 1'b1;
        clear_iq();
        set_lane(0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd13, 3'b100, 1'b0, 8'h51);
        set_lane(1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b1, 5'd14, 3'b100, 1'b0, 8'h52);
        bus.iq_size = 2'd2;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (bus.iq_pop_number !== 2'd0) begin
                n_fail++;
                $display("FAIL stall_pop cycle %0d got %0d want 0", c, bus.iq_pop_number);
            end
            exp_q.push_back(hold);
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (fu_snap(e.v) !== e || dut.sb_pos[1] !== 3'b100) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d got fu=%h pos=%b want fu=%h pos=100", c, fu_snap(e.v), dut.sb_pos[1], e);
            end
        end
        bus.ex_stall = 1'b0;
        drain();
    endtask

    task automatic test_flush();
        exp_t e;
        clear_iq();
        set_lane(0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd8, 3'b010, 1'b0, 8'h60);
        bus.iq_size = 2'd1;
        #1;
        exp_q.push_back(mk(2'b01, rf(5'd2), rf(5'd3), pay_of(8'h60), 32'h0, 32'h0, 96'h0));
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (fu_snap(e.v) !== e) begin
            n_fail++;
            $display("FAIL flush_r8_fu got %h want %h", fu_snap(e.v), e);
        end
        set_lane(0, 5'd4, 1'b1, 5'd5, 1'b1, 1'b1, 5'd9, 3'b100, 1'b0, 8'h61);
        #1;
        n_tests++;
        if (bus.iq_pop_number !== 2'd1) begin
            n_fail++;
            $display("FAIL flush_r9_pop got %0d want 1", bus.iq_pop_number);
        end
        tick();
        n_tests++;
        if (dut.sb_pos[8] !== 3'b010 || dut.sb_pos[9] !== 3'b100) begin
            n_fail++;
            $display("FAIL flush_pre_sb got r8=%b r9=%b want 010 100", dut.sb_pos[8], dut.sb_pos[9]);
        end
        // Flush wins over a simultaneous stall
        bus.flush    = 1'b1;
        bus.ex_stall = 1'b1;
        set_lane(0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd15, 3'b100, 1'b0, 8'h62);
        #1;
        n_tests++;
        if (bus.iq_pop_number !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_pop got %0d want 0", bus.iq_pop_number);
        end
        exp_q.push_back(mk(2'b00, 32'h0, 32'h0, 96'h0, 32'h0, 32'h0, 96'h0));
        tick();
        bus.flush    = 1'b0;
        bus.ex_stall = 1'b0;
        clear_iq();
        e = exp_q.pop_front();
        n_tests++;
        if (fu_snap(e.v) !== e) begin
            n_fail++;
            $display("FAIL flush_fu got %h want %h", fu_snap(e.v), e);
        end
        n_tests++;
        if (dut.sb_pos[9] !== 3'b000 || dut.sb_pos[8] !== 3'b001 || dut.sb_pos[15] !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_sb got r8=%b r9=%b r15=%b want 001 000 000", dut.sb_pos[8], dut.sb_pos[9], dut.sb_pos[15]);
        end
        drain();
    endtask

    task automatic test_waw();
        exp_t e;
        clear_iq();
        set_lane(0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd12, 3'b100, 1'b0, 8'h70);
        set_lane(1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b1, 5'd12, 3'b100, 1'b0, 8'h71);
        bus.iq_size = 2'd2;
        #1;
        n_tests++;
        if (bus.iq_pop_number !== 2'd2) begin
            n_fail++;
            $display("FAIL waw_pop got %0d want 2", bus.iq_pop_number);
        end
        exp_q.push_back(mk(2'b11, rf(5'd2), rf(5'd3), pay_of(8'h70), rf(5'd4), rf(5'd5), pay_of(8'h71)));
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (fu_snap(e.v) !== e) begin
            n_fail++;
            $display("FAIL waw_fu got %h want %h", fu_snap(e.v), e);
        end
        clear_iq();
        set_lane(0, 5'd12, 1'b1, 5'd0, 1'b0, 1'b1, 5'd13, 3'b100, 1'b0, 8'h72);
        bus.iq_size = 2'd1;
        #1;
        n_tests++;
        if (bus.iq_pop_number !== 2'd1 || bus.bypass_sel[3:0] !== 4'b1001) begin
            n_fail++;
            $display("FAIL waw_consumer got pop=%0d sel=%b want 1 1001", bus.iq_pop_number, bus.bypass_sel[3:0]);
        end
        exp_q.push_back(mk(2'b01, byp(0, 4'b1001), imm_of(1), pay_of(8'h72), 32'h0, 32'h0, 96'h0));
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (fu_snap(e.v) !== e) begin
            n_fail++;
            $display("FAIL waw_consumer_fu got %h want %h", fu_snap(e.v), e);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        clear_iq();
        set_lane(0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1, 3'b100, 1'b0, 8'h80);
        bus.iq_size = 2'd1;
        tick();
        rst = 1'b1;
        clear_iq();
        tick();
        rst = 1'b0;
        n_tests++;
        if (dut.sb_pos[1] !== 3'b000 || bus.fu_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid got pos=%b v=%b want 000 00", dut.sb_pos[1], bus.fu_valid);
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_back_to_back();
        test_load_use();
        test_branch();
        test_stall();
        test_flush();
        test_waw();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
